// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the ID/EX stage and the hazard logic.
// Also provides the write-back bypass select used on the register-file operands.
package pipe_pkg;
  localparam int REG_W          = 32;
  localparam int RADDR_W        = 5;
  localparam int CTRL_W_DEFAULT = 8;

  localparam logic [RADDR_W-1:0]        ZERO_REG    = 5'd0;
  localparam logic [CTRL_W_DEFAULT-1:0] BUBBLE_CTRL = '0;

  typedef struct packed {
    logic               valid;
    logic [REG_W-1:0]   pc;
    logic [RADDR_W-1:0] rs1;
    logic [RADDR_W-1:0] rs2;
    logic [RADDR_W-1:0] rd;
    logic [REG_W-1:0]   data1;
    logic [REG_W-1:0]   data2;
    logic [REG_W-1:0]   imm;
    logic               mem_read;
    logic               reg_write;
  } ex_slot_t;

  // WB writes the register file in the same cycle ID reads it; x0 is never bypassed.
  function automatic logic [REG_W-1:0] wb_bypass(
    input logic               we,
    input logic [RADDR_W-1:0] wb_rd,
    input logic [REG_W-1:0]   wb_data,
    input logic [RADDR_W-1:0] rs,
    input logic [REG_W-1:0]   rf_data
  );
    return (we && (wb_rd != ZERO_REG) && (wb_rd == rs)) ? wb_data : rf_data;
  endfunction
endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: ID-side inputs, WB bypass, flush, and the registered EX slot.
// The slave modport is the stage itself; master is whatever drives ID and consumes EX.
interface id_ex_stage_if #(
  parameter int CTRL_W = pipe_pkg::CTRL_W_DEFAULT,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [31:0]       id_pc;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic [4:0]        id_rd;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [31:0]       id_data1;
  logic [31:0]       id_data2;
  logic [31:0]       id_imm;
  logic              id_mem_read;
  logic              id_reg_write;
  logic [CTRL_W-1:0] id_ctrl;
  logic              wb_we;
  logic [4:0]        wb_rd;
  logic [31:0]       wb_data;
  logic              flush;

  logic              stall;
  logic              ex_valid;
  logic [31:0]       ex_pc;
  logic [4:0]        ex_rs1;
  logic [4:0]        ex_rs2;
  logic [4:0]        ex_rd;
  logic [31:0]       ex_data1;
  logic [31:0]       ex_data2;
  logic [31:0]       ex_imm;
  logic              ex_mem_read;
  logic              ex_reg_write;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_data1, id_data2, id_imm, id_mem_read, id_reg_write, id_ctrl,
           wb_we, wb_rd, wb_data, flush,
    input  stall, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_data1, ex_data2,
           ex_imm, ex_mem_read, ex_reg_write, ex_ctrl, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_data1, id_data2, id_imm, id_mem_read, id_reg_write, id_ctrl,
           wb_we, wb_rd, wb_data, flush,
    output stall, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_data1, ex_data2,
           ex_imm, ex_mem_read, ex_reg_write, ex_ctrl, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: a load sitting in EX whose rd is read by the ID instruction.
// Flush suppresses the stall because the ID instruction is being killed anyway.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic               ex_valid_i,
  input  logic               ex_mem_read_i,
  input  logic [RADDR_W-1:0] ex_rd_i,
  input  logic               id_valid_i,
  input  logic               id_use_rs1_i,
  input  logic [RADDR_W-1:0] id_rs1_i,
  input  logic               id_use_rs2_i,
  input  logic [RADDR_W-1:0] id_rs2_i,
  input  logic               flush_i,
  output logic               hz_o,
  output logic               stall_o
);
  logic src_match;

  assign src_match = (id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                     (id_use_rs2_i && (id_rs2_i == ex_rd_i));

  assign hz_o    = ex_valid_i && ex_mem_read_i && (ex_rd_i != ZERO_REG) &&
                   id_valid_i && src_match;
  assign stall_o = hz_o && !flush_i;
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, WB bypass and flush.
// Saturating stall/flush event counters are kept here for debug display.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEFAULT,
  parameter int CNT_W  = 16
) (
  input  logic         clk,
  input  logic         rst,
  id_ex_stage_if.slave bus
);
  ex_slot_t          ex_q, ex_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              hz;
  logic              stall;
  logic [REG_W-1:0]  op1, op2;

  hazard_detect u_hazard_detect (
    .ex_valid_i    (ex_q.valid),
    .ex_mem_read_i (ex_q.mem_read),
    .ex_rd_i       (ex_q.rd),
    .id_valid_i    (bus.id_valid),
    .id_use_rs1_i  (bus.id_use_rs1),
    .id_rs1_i      (bus.id_rs1),
    .id_use_rs2_i  (bus.id_use_rs2),
    .id_rs2_i      (bus.id_rs2),
    .flush_i       (bus.flush),
    .hz_o          (hz),
    .stall_o       (stall)
  );

  assign op1 = wb_bypass(bus.wb_we, bus.wb_rd, bus.wb_data, bus.id_rs1, bus.id_data1);
  assign op2 = wb_bypass(bus.wb_we, bus.wb_rd, bus.wb_data, bus.id_rs2, bus.id_data2);

  // Bubbles zero only the control side; data/PC fields simply hold.
  always_comb begin
    ex_d        = ex_q;
    ctrl_d      = ctrl_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.flush) begin
      ex_d.valid     = 1'b0;
      ex_d.mem_read  = 1'b0;
      ex_d.reg_write = 1'b0;
      ctrl_d         = CTRL_W'(BUBBLE_CTRL);
      if (!(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else if (hz) begin
      ex_d.valid     = 1'b0;
      ex_d.mem_read  = 1'b0;
      ex_d.reg_write = 1'b0;
      ctrl_d         = CTRL_W'(BUBBLE_CTRL);
      if (!(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      ex_d.valid     = bus.id_valid;
      ex_d.pc        = bus.id_pc;
      ex_d.rs1       = bus.id_rs1;
      ex_d.rs2       = bus.id_rs2;
      ex_d.rd        = bus.id_rd;
      ex_d.data1     = op1;
      ex_d.data2     = op2;
      ex_d.imm       = bus.id_imm;
      ex_d.mem_read  = bus.id_valid && bus.id_mem_read;
      ex_d.reg_write = bus.id_valid && bus.id_reg_write;
      ctrl_d         = bus.id_valid ? bus.id_ctrl : CTRL_W'(BUBBLE_CTRL);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q        <= '0;
      ctrl_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      ctrl_q      <= ctrl_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall        = stall;
  assign bus.ex_valid     = ex_q.valid;
  assign bus.ex_pc        = ex_q.pc;
  assign bus.ex_rs1       = ex_q.rs1;
  assign bus.ex_rs2       = ex_q.rs2;
  assign bus.ex_rd        = ex_q.rd;
  assign bus.ex_data1     = ex_q.data1;
  assign bus.ex_data2     = ex_q.data2;
  assign bus.ex_imm       = ex_q.imm;
  assign bus.ex_mem_read  = ex_q.mem_read;
  assign bus.ex_reg_write = ex_q.reg_write;
  assign bus.ex_ctrl      = ctrl_q;
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.flush_cnt    = flush_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard/bypass/flush cases, random
// traffic against a scoreboard of predicted EX slots, mid-run reset and counter saturation.
module tb_id_ex_stage;
  import pipe_pkg::*;

  localparam int CTRL_W = CTRL_W_DEFAULT;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_if #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

  id_ex_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic              valid;
    logic [31:0]       pc;
    logic [4:0]        rs1, rs2, rd;
    logic [31:0]       d1, d2, imm;
    logic              mr, rw;
    logic [CTRL_W-1:0] ctrl;
    logic [CNT_W-1:0]  scnt, fcnt;
  } exp_t;

  exp_t m;
  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
    n_tests++;
    if (obs !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, req);
    end
  endtask

  task automatic model_reset();
    m = '{default: '0};
    exp_q.delete();
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rf);
    if (bus.wb_we && bus.wb_rd != 5'd0 && bus.wb_rd == rs) return bus.wb_data;
    return rf;
  endfunction

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic u1, input logic u2,
                        input logic mr, input logic rw, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] imm);
    bus.id_valid     = v;
    bus.id_pc        = $urandom;
    bus.id_rs1       = rs1;
    bus.id_rs2       = rs2;
    bus.id_rd        = rd;
    bus.id_use_rs1   = u1;
    bus.id_use_rs2   = u2;
    bus.id_mem_read  = mr;
    bus.id_reg_write = rw;
    bus.id_data1     = d1;
    bus.id_data2     = d2;
    bus.id_imm       = imm;
    bus.id_ctrl      = CTRL_W'($urandom);
  endtask

  task automatic set_wb(input logic we, input logic [4:0] rd, input logic [31:0] data);
    bus.wb_we   = we;
    bus.wb_rd   = rd;
    bus.wb_data = data;
  endtask

  task automatic compare_out(input exp_t e);
    check("ex_valid", bus.ex_valid, e.valid);
    check("ex_pc", bus.ex_pc, e.pc);
    check("ex_rs1", bus.ex_rs1, e.rs1);
    check("ex_rs2", bus.ex_rs2, e.rs2);
    check("ex_rd", bus.ex_rd, e.rd);
    check("ex_data1", bus.ex_data1, e.d1);
    check("ex_data2", bus.ex_data2, e.d2);
    check("ex_imm", bus.ex_imm, e.imm);
    check("ex_mem_read", bus.ex_mem_read, e.mr);
    check("ex_reg_write", bus.ex_reg_write, e.rw);
    check("ex_ctrl", bus.ex_ctrl, e.ctrl);
    check("stall_cnt", bus.stall_cnt, e.scnt);
    check("flush_cnt", bus.flush_cnt, e.fcnt);
  endtask

  // One clock: check combinational stall, predict the next EX slot, compare after the edge.
  task automatic cycle();
    logic hz_e;
    exp_t nx;
    hz_e = m.valid && m.mr && (m.rd != 5'd0) && bus.id_valid &&
           ((bus.id_use_rs1 && bus.id_rs1 == m.rd) || (bus.id_use_rs2 && bus.id_rs2 == m.rd));
    #1;
    check("stall", bus.stall, hz_e && !bus.flush);
    nx = m;
    if (bus.flush || hz_e) begin
      nx.valid = 1'b0;
      nx.mr    = 1'b0;
      nx.rw    = 1'b0;
      nx.ctrl  = '0;
      if (bus.flush) begin
        if (nx.fcnt != {CNT_W{1'b1}}) nx.fcnt = nx.fcnt + 1'b1;
      end else begin
        if (nx.scnt != {CNT_W{1'b1}}) nx.scnt = nx.scnt + 1'b1;
      end
    end else begin
      nx.valid = bus.id_valid;
      nx.pc    = bus.id_pc;
      nx.rs1   = bus.id_rs1;
      nx.rs2   = bus.id_rs2;
      nx.rd    = bus.id_rd;
      nx.d1    = fwd(bus.id_rs1, bus.id_data1);
      nx.d2    = fwd(bus.id_rs2, bus.id_data2);
      nx.imm   = bus.id_imm;
      nx.mr    = bus.id_valid && bus.id_mem_read;
      nx.rw    = bus.id_valid && bus.id_reg_write;
      nx.ctrl  = bus.id_valid ? bus.id_ctrl : '0;
    end
    exp_q.push_back(nx);
    m = nx;
    @(posedge clk);
    #1;
    compare_out(exp_q.pop_front());
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with random inputs
    set_id(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, 1'b1, 1'b1,
           $urandom, $urandom, $urandom);
    set_wb(1'b1, 5'($urandom), $urandom);
    bus.flush = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", bus.ex_valid, 1'b0);
    check("rst_pc", bus.ex_pc, 32'h0);
    check("rst_data1", bus.ex_data1, 32'h0);
    check("rst_ctrl", bus.ex_ctrl, '0);
    check("rst_stall", bus.stall, 1'b0);
    check("rst_scnt", bus.stall_cnt, '0);
    check("rst_fcnt", bus.flush_cnt, '0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    bus.flush = 1'b0;
    set_wb(1'b0, 5'd0, 32'h0);

    // Plain pass-through
    set_id(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1000_0000, 32'h22, 32'hFFFF_FFFC);
    cycle();
    check("pt_data1", bus.ex_data1, 32'h1000_0000);
    check("pt_imm", bus.ex_imm, 32'hFFFF_FFFC);
    check("pt_rd", bus.ex_rd, 5'd5);
    check("pt_valid", bus.ex_valid, 1'b1);

    // Load-use: lw x6 then add reading x6 through rs2
    set_id(1'b1, 5'd1, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 32'h8);
    cycle();
    set_id(1'b1, 5'd7, 5'd6, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 32'h77, 32'h66, 32'h0);
    #1;
    check("lu_stall", bus.stall, 1'b1);
    cycle();
    check("lu_bubble", bus.ex_valid, 1'b0);
    check("lu_scnt", bus.stall_cnt, 16'd1);
    check("lu_clear", bus.stall, 1'b0);
    cycle();
    check("lu_capture_rd", bus.ex_rd, 5'd8);

    // Same pattern without rs2 use, then with a load to x0
    set_id(1'b1, 5'd1, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 32'h8);
    cycle();
    set_id(1'b1, 5'd7, 5'd6, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 32'h77, 32'h66, 32'h0);
    #1;
    check("nouse_stall", bus.stall, 1'b0);
    cycle();
    set_id(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 32'h8);
    cycle();
    set_id(1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 32'h77, 32'h66, 32'h0);
    #1;
    check("x0_stall", bus.stall, 1'b0);
    cycle();

    // WB bypass, and no bypass from x0
    set_wb(1'b1, 5'd2, 32'hAAAA_5555);
    set_id(1'b1, 5'd2, 5'd9, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1F4, 32'h99, 32'h4);
    cycle();
    check("byp_data1", bus.ex_data1, 32'hAAAA_5555);
    set_wb(1'b1, 5'd0, 32'hAAAA_5555);
    set_id(1'b1, 5'd0, 5'd9, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1F4, 32'h99, 32'h4);
    cycle();
    check("byp_x0_data1", bus.ex_data1, 32'h1F4);
    set_wb(1'b0, 5'd0, 32'h0);

    // Flush wins over an active hazard
    set_id(1'b1, 5'd1, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 32'h8);
    cycle();
    set_id(1'b1, 5'd7, 5'd6, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 32'h77, 32'h66, 32'h0);
    bus.flush = 1'b1;
    #1;
    check("fl_stall", bus.stall, 1'b0);
    cycle();
    check("fl_valid", bus.ex_valid, 1'b0);
    check("fl_fcnt", bus.flush_cnt, 16'd1);
    check("fl_scnt", bus.stall_cnt, 16'd1);
    bus.flush = 1'b0;

    // Random traffic with small register numbers so hazards and bypasses are frequent
    for (int i = 0; i < 400; i++) begin
      set_id(1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), $urandom, $urandom, $urandom);
      set_wb(1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      bus.flush = ($urandom_range(0, 7) == 0);
      cycle();
    end

    // Asynchronous reset mid-stream, away from any clock edge
    set_id(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 32'h5, 32'h6, 32'h7);
    bus.flush = 1'b0;
    cycle();
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", bus.ex_valid, 1'b0);
    check("arst_rd", bus.ex_rd, 5'd0);
    check("arst_mr", bus.ex_mem_read, 1'b0);
    check("arst_scnt", bus.stall_cnt, '0);
    check("arst_fcnt", bus.flush_cnt, '0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    // Flush counter saturation
    bus.flush = 1'b1;
    for (int i = 0; i < (1 << CNT_W) + 3; i++) cycle();
    check("fcnt_sat", bus.flush_cnt, 16'hFFFF);
    bus.flush = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
